// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per clock,
// chaining the carry through a register, with valid/ready on both sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("digit_serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             accept, step, last;
  logic [DIGIT:0]   digit_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] a_shift, b_shift, res_shift;

  // Signed overflow: the carry entering the MSB disagrees with the carry leaving it.
  function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

  assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};
  // Carry into the digit's top bit recovered from the top bit's half-sum.
  assign msb_cin   = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ digit_sum[DIGIT-1];

  generate
    if (N == 1) begin : g_single_digit
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign res_shift = digit_sum[DIGIT-1:0];
    end else begin : g_multi_digit
      assign a_shift   = {{DIGIT{1'b0}}, a_sr[WIDTH-1:DIGIT]};
      assign b_shift   = {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
      assign res_shift = {digit_sum[DIGIT-1:0], res_sr[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CNT_W'(N - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers, carry chain and result holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr  <= in_a;
      b_sr  <= in_sub ? ~in_b : in_b;
      carry <= in_sub ? 1'b1 : in_cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr   <= a_shift;
      b_sr   <= b_shift;
      res_sr <= res_shift;
      carry  <= digit_sum[DIGIT];
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum_q  <= res_shift;
        cout_q <= digit_sum[DIGIT];
        ovf_q  <= signed_ovf(msb_cin, digit_sum[DIGIT]);
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four instances (16/4, 8/1, 8/8, 12/3) sharing an
// operand bus, each with its own handshake lines, checked against an A+/-B model.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_bus, b_bus;
  logic        cin_bus, sub_bus;
  logic [3:0]  iv, ordy;
  wire  [3:0]  irdy, ovld, cout_v, ovf_v;
  wire  [15:0] sum0;
  wire  [7:0]  sum1, sum2;
  wire  [11:0] sum3;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(a_bus), .in_b(b_bus), .in_cin(cin_bus), .in_sub(sub_bus),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(sum0),
    .out_cout(cout_v[0]), .out_ovf(ovf_v[0]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_cin(cin_bus), .in_sub(sub_bus),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(sum1),
    .out_cout(cout_v[1]), .out_ovf(ovf_v[1]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_cin(cin_bus), .in_sub(sub_bus),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(sum2),
    .out_cout(cout_v[2]), .out_ovf(ovf_v[2]));

  digit_serial_adder #(.WIDTH(12), .DIGIT(3)) u_w12d3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .in_a(a_bus[11:0]), .in_b(b_bus[11:0]), .in_cin(cin_bus), .in_sub(sub_bus),
    .out_valid(ovld[3]), .out_ready(ordy[3]), .out_sum(sum3),
    .out_cout(cout_v[3]), .out_ovf(ovf_v[3]));

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic int w_of(input int k);
    case (k)
      0:       return 16;
      3:       return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int k);
    case (k)
      0:       return sum0;
      1:       return {8'h00, sum1};
      2:       return {8'h00, sum2};
      default: return {4'h0, sum3};
    endcase
  endfunction

  // Reference: full-width A+B+cin or A-B done as integer arithmetic on w bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [16:0] full;
    logic [15:0] mask, am, bm, bb;
    exp_t        e;
    mask = 16'((17'd1 << w) - 17'd1);
    am   = a & mask;
    bm   = b & mask;
    bb   = sub ? (~bm & mask) : bm;
    full = {1'b0, am} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    e.sum  = full[15:0] & mask;
    e.cout = full[w];
    if (sub) e.ovf = (am[w-1] != bm[w-1]) && (e.sum[w-1] != am[w-1]);
    else     e.ovf = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  // One full transaction on instance k; caller is positioned 1 time unit after a rising edge.
  task automatic do_txn(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int hold,
                        input logic intrude, input string name);
    int          lat;
    int          waitc;
    exp_t        e;
    logic [15:0] snap;
    a_bus   = a;
    b_bus   = b;
    cin_bus = cin;
    sub_bus = sub;
    iv[k]   = 1'b1;
    waitc   = 0;
    while (irdy[k] !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    iv[k] = 1'b0;
    exp_q.push_back(model(w_of(k), a, b, cin, sub));
    lat = 0;
    while (ovld[k] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != n_of(k)) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, lat, n_of(k));
    end
    e    = exp_q.pop_front();
    snap = get_sum(k);
    for (int h = 0; h < hold; h++) begin
      if (intrude) begin
        a_bus = ~a;
        b_bus = a;
        iv[k] = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if (ovld[k] !== 1'b1 || irdy[k] !== 1'b0 || get_sum(k) !== snap) begin
        miscompares++;
        $display("FAIL %s hold[%0d]: valid=%b ready=%b sum=%h, want valid=1 ready=0 sum=%h",
                 name, h, ovld[k], irdy[k], get_sum(k), snap);
      end
    end
    iv[k] = 1'b0;
    vectors++;
    if (get_sum(k) !== e.sum) begin
      miscompares++;
      $display("FAIL %s sum: got %h, want %h", name, get_sum(k), e.sum);
    end
    vectors++;
    if (cout_v[k] !== e.cout || ovf_v[k] !== e.ovf) begin
      miscompares++;
      $display("FAIL %s flags: got cout=%b ovf=%b, want cout=%b ovf=%b",
               name, cout_v[k], ovf_v[k], e.cout, e.ovf);
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    vectors++;
    if (irdy[k] !== 1'b1 || ovld[k] !== 1'b0 || get_sum(k) !== e.sum) begin
      miscompares++;
      $display("FAIL %s after handshake: ready=%b valid=%b sum=%h, want ready=1 valid=0 sum=%h",
               name, irdy[k], ovld[k], get_sum(k), e.sum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sum0 !== 16'h0 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 ||
        ovld !== 4'b0000 || irdy !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset: sum=%h cout=%b ovf=%b valid=%b ready=%b, want 0 0 0 0000 1111",
               sum0, cout_v[0], ovf_v[0], ovld, irdy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1 0", irdy[0], ovld[0]);
    end
  endtask

  task automatic test_add();
    do_txn(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, "add_1234_4321");
    do_txn(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "add_ffff_0001");
    do_txn(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "add_7fff_0001");
    do_txn(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "add_cin");
    do_txn(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 1, 1'b0, "add_neg_ovf");
  endtask

  task automatic test_sub();
    do_txn(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, "sub_5_7");
    do_txn(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, "sub_8000_1");
    do_txn(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, "sub_cin_ignored");
    do_txn(0, 16'h1234, 16'h1234, 1'b1, 1'b1, 0, 1'b0, "sub_equal");
  endtask

  task automatic test_backpressure();
    do_txn(0, 16'hA5A5, 16'h1111, 1'b1, 1'b0, 3, 1'b1, "backpressure");
    do_txn(0, 16'h0100, 16'h0200, 1'b0, 1'b1, 0, 1'b0, "after_backpressure");
  endtask

  task automatic test_async_reset();
    a_bus   = 16'h1111;
    b_bus   = 16'h2222;
    cin_bus = 1'b0;
    sub_bus = 1'b0;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (sum0 !== 16'h0 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 || ovld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: sum=%h cout=%b ovf=%b valid=%b, want all 0",
               sum0, cout_v[0], ovf_v[0], ovld[0]);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_release: ready=%b valid=%b, want 1 0", irdy[0], ovld[0]);
    end
    do_txn(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "after_async_reset");
  endtask

  task automatic test_sweep();
    logic [15:0] a, b;
    logic        cin, sub;
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < 1000; i++) begin
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        do_txn(k, a, b, cin, sub, int'($urandom_range(0, 2)), 1'b0, $sformatf("sweep%0d_%0d", k, i));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    iv      = 4'b0000;
    ordy    = 4'b0000;
    a_bus   = '0;
    b_bus   = '0;
    cin_bus = 1'b0;
    sub_bus = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_async_reset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, sequential successor to the single-bit full_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
- A carry register is chained across cycles.
- Valid/ready handshakes sit on both sides. It is the area-cheap arithmetic primitive for datapaths that tolerate multi-cycle latency.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly and satisfy 1 <= DIGIT <= WIDTH. A violation is an elaboration error.
- Derived: N = WIDTH/DIGIT, the number of digit cycles; counter width is clog2(N+1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; used in add mode only
- in_sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1 with in_cin ignored
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result, modulo 2^WIDTH
- out_cout  output  1  carry out of MSB; in subtract mode 1 means no borrow
- out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - State goes to IDLE, the digit counter and carry register clear, and the operand shift registers clear.
  - Outputs: out_sum=0, out_cout=0, out_ovf=0, out_valid=0, in_ready=1 while in IDLE.
  - Reset during BUSY or DONE aborts the transaction; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, the transaction is accepted:
    - latch in_a; latch in_b, or ~in_b when in_sub=1;
    - carry register <= (in_sub ? 1 : in_cin);
    - counter <= 0; go to BUSY.
  - in_valid=0 keeps the block in IDLE.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge adds the low DIGIT bits of both operand registers plus the carry. Operands shift right by DIGIT, the sum digit enters the top of the result shift register, the carry register updates, and the counter increments.
  - On the digit where counter==N-1:
    - record the carry into bit WIDTH-1 (the internal carry of that digit's MSB position);
    - load out_sum, out_cout and out_ovf from the completed result;
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout and out_ovf are held stable for as long as out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - No same-cycle accept: a new operand can be taken at the earliest one cycle after the result handshake.
- Latency: out_valid rises exactly N rising edges after the accepting edge. Throughput is one result per N+2 cycles with out_ready tied high.
- Output persistence: out_sum, out_cout and out_ovf keep their last result after the DONE→IDLE transition and change only when the next transaction completes. Inputs are ignored outside IDLE.
- DIGIT=WIDTH (N=1) is a legal degenerate case: one BUSY cycle. The counter must not wrap or underflow in this case.
- Intermediate sums are computed at DIGIT+1 bits; no other width growth.

Test Plan:
- WIDTH=16, DIGIT=4, add, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 4 edges after accept; sum=0x5555, cout=0, ovf=0; in_ready back to 1 on the following cycle.
- Add a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Add a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Add a=0x0000, b=0x0000, cin=1 → sum=0x0001.
- Sub a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Sub a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. in_cin=1 during sub has no effect.
- Backpressure:
  - result ready, out_ready held low for 3 cycles → out_valid stays 1, outputs are stable, in_ready=0;
  - a simultaneous in_valid with new operands is ignored;
  - out_ready=1 → IDLE; the next accepted transaction computes correctly.
- Reset asserted asynchronously during the 2nd BUSY digit (no clock edge) → outputs go to 0 and out_valid=0 immediately; after release in_ready=1; the next add of 0x00FF+0x0001 gives 0x0100.
- Parameter sweep:
  - WIDTH=8, DIGIT=1 → latency 8;
  - WIDTH=8, DIGIT=8 → latency 1;
  - WIDTH=12, DIGIT=3 → latency 4;
  - each with 1000 random add/sub transactions and random out_ready, compared against an (A±B) model including cout/ovf.
